// File: rtl/rdm_rr.sv
// rdm_rr: round-robin drain of CH FIFO channels into one destination stream.
// Each grant reads up to BURST words from one channel. FIFO read data arrives
// the cycle after the strobe and is registered once more, so a word appears on
// ov_data two cycles after its strobe.
module rdm_rr #(
  parameter  int DW    = 8,
  parameter  int CH    = 4,
  parameter  int BURST = 16,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1,
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CH-1:0]     iv_fifo_empty,
  input  logic [CH*DW-1:0]  iv_fifo_data,
  input  logic [CH-1:0]     iv_ch_en,
  input  logic              i_dst_ready,
  output logic [CH-1:0]     ov_fifo_rd,
  output logic [DW-1:0]     ov_data,
  output logic              o_data_wr,
  output logic [CHW-1:0]    ov_data_ch,
  output logic              o_data_sop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01
  } state_e;

  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  state_e         state_q;
  logic [CHW-1:0] last_q;      // last granted channel, rotation origin
  logic [CHW-1:0] gnt_q;       // channel owning the current grant
  logic [CW-1:0]  cnt_q;       // strobes issued in the current grant
  logic [CH-1:0]  elig;
  logic           gnt_elig;
  logic           strobe;
  logic           nxt_vld;
  logic [CHW-1:0] nxt_ch;

  // [0]: strobe issued last cycle (FIFO data on the bus now); [1]: word on ov_data
  logic [1:0]     vld_pipe_q;
  logic           sop1_q;
  logic [CHW-1:0] ch1_q;

  assign elig     = ~iv_fifo_empty & iv_ch_en;
  assign gnt_elig = elig[gnt_q];
  // Reset gates the strobe so no FIFO word is consumed while in reset.
  assign strobe   = i_rst_n && (state_q == S_READ) && gnt_elig && i_dst_ready &&
                    (cnt_q < BURST_C);

  // One-hot read strobe on the granted channel.
  always_comb begin
    ov_fifo_rd = '0;
    if (strobe) ov_fifo_rd[gnt_q] = 1'b1;
  end

  // First eligible channel after last_q, wrapping; descending scan so the
  // closest candidate is the final assignment.
  always_comb begin
    logic [CHW-1:0] idx;
    idx     = '0;
    nxt_vld = 1'b0;
    nxt_ch  = last_q;
    for (int i = CH; i >= 1; i--) begin
      idx = CHW'((int'(last_q) + i) % CH);
      if (elig[idx]) begin
        nxt_vld = 1'b1;
        nxt_ch  = idx;
      end
    end
  end

  // Grant FSM: IDLE picks the next channel, READ streams until burst done or
  // the channel stops being eligible.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= CHW'(CH - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (nxt_vld) begin
            gnt_q   <= nxt_ch;
            last_q  <= nxt_ch;
            cnt_q   <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          // strobe implies cnt_q < BURST, so the counter never wraps
          if (strobe) cnt_q <= cnt_q + 1'b1;
          if (!gnt_elig || (cnt_q >= BURST_C) ||
              (strobe && (cnt_q == BURST_C - 1'b1)))
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Capture pipeline: tag the strobe, then register the FIFO word one cycle later.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe_q <= '0;
      sop1_q     <= 1'b0;
      ch1_q      <= '0;
      o_data_sop <= 1'b0;
      ov_data    <= '0;
      ov_data_ch <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], strobe};
      ch1_q      <= gnt_q;
      sop1_q     <= strobe && (cnt_q == '0);
      o_data_sop <= vld_pipe_q[0] && sop1_q;
      if (vld_pipe_q[0]) begin
        ov_data    <= iv_fifo_data[ch1_q*DW +: DW];
        ov_data_ch <= ch1_q;
      end
    end
  end

  assign o_data_wr = vld_pipe_q[1];

endmodule

// File: tb/tb_rdm_rr.sv
// tb_rdm_rr: queue-based FIFO model plus scoreboard for rdm_rr.
module tb_rdm_rr;
  localparam int DW = 8, CH = 4, BURST = 16, CHW = 2;

  logic             i_clk = 1'b0, i_rst_n = 1'b0, i_dst_ready = 1'b1;
  logic [CH-1:0]    iv_fifo_empty = '1, iv_ch_en = '1;
  logic [CH*DW-1:0] iv_fifo_data = '0;
  logic [CH-1:0]    ov_fifo_rd;
  logic [DW-1:0]    ov_data;
  logic             o_data_wr, o_data_sop;
  logic [CHW-1:0]   ov_data_ch;

  rdm_rr #(.DW(DW), .CH(CH), .BURST(BURST)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_fifo_empty(iv_fifo_empty),
    .iv_fifo_data(iv_fifo_data), .iv_ch_en(iv_ch_en), .i_dst_ready(i_dst_ready),
    .ov_fifo_rd(ov_fifo_rd), .ov_data(ov_data), .o_data_wr(o_data_wr),
    .ov_data_ch(ov_data_ch), .o_data_sop(o_data_sop));

  always #5 i_clk = ~i_clk;

  typedef struct { int cyc; int ch; } slog_t;
  typedef struct { int cyc; int ch; logic [DW-1:0] data; bit sop; } ent_t;

  logic [DW-1:0] fifo_q [CH][$];
  slog_t slog[$];
  ent_t  expq[$], outlog[$];
  int n_chk = 0, n_pass = 0, cyc = 0, pend_ch = -1;
  int cur_ch = 0, cur_cnt = 0, last_strobe = -100;
  bit grant_open = 0;
  logic [DW-1:0] last_data = '0;
  int last_ch = 0;

  // FIFO model: pop on the strobe seen last cycle, present the word now.
  always @(posedge i_clk) begin
    #1;
    if (pend_ch >= 0 && fifo_q[pend_ch].size() > 0)
      iv_fifo_data[pend_ch*DW +: DW] = fifo_q[pend_ch].pop_front();
    for (int k = 0; k < CH; k++) iv_fifo_empty[k] = (fifo_q[k].size() == 0);
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge i_clk) begin
    logic [CH-1:0] el;
    int k;
    bit newg;
    ent_t e;
    cyc++;
    pend_ch = -1;
    if (!i_rst_n) begin
      expq.delete(); grant_open = 0; last_data = '0; last_ch = 0; last_strobe = -100;
      n_chk++;
      if (ov_fifo_rd !== '0) $display("FAIL rd_in_reset: got %b want 0", ov_fifo_rd);
      else n_pass++;
    end else begin
      el = ~iv_fifo_empty & iv_ch_en;
      if (grant_open && !el[cur_ch]) grant_open = 0;
      if (ov_fifo_rd !== '0) begin
        k = 0;
        for (int i = 0; i < CH; i++) if (ov_fifo_rd[i]) k = i;
        n_chk++;
        if ($countones(ov_fifo_rd) != 1) $display("FAIL rd_onehot: got %b want one bit", ov_fifo_rd);
        else n_pass++;
        n_chk++;
        if (!(el[k] && i_dst_ready)) $display("FAIL rd_legal: ch %0d elig %b ready %b want both 1", k, el[k], i_dst_ready);
        else n_pass++;
        newg = !grant_open || (cur_ch != k);
        if (newg) begin
          n_chk++;
          if (cyc - last_strobe < 2) $display("FAIL grant_gap: got %0d cycles want >=2", cyc - last_strobe);
          else n_pass++;
          cur_ch = k; cur_cnt = 0; grant_open = 1;
        end
        cur_cnt++;
        if (cur_cnt == BURST) grant_open = 0;
        if (fifo_q[k].size() > 0) expq.push_back('{cyc, k, fifo_q[k][0], newg});
        slog.push_back('{cyc, k});
        pend_ch = k;
        last_strobe = cyc;
      end
      if (o_data_wr === 1'b1) begin
        n_chk++;
        if (expq.size() == 0) begin
          $display("FAIL unexpected_wr: got wr=1 data %h want no word", ov_data);
          last_data = ov_data; last_ch = ov_data_ch;
        end else begin
          e = expq.pop_front();
          if (ov_data !== e.data || ov_data_ch !== CHW'(e.ch) || o_data_sop !== e.sop || cyc - e.cyc != 2)
            $display("FAIL out_word: got d=%h ch=%0d sop=%b lat=%0d want d=%h ch=%0d sop=%b lat=2",
                     ov_data, ov_data_ch, o_data_sop, cyc - e.cyc, e.data, e.ch, e.sop);
          else n_pass++;
          last_data = e.data; last_ch = e.ch;
          outlog.push_back('{cyc, e.ch, e.data, e.sop});
        end
      end else begin
        n_chk++;
        if (ov_data !== last_data || ov_data_ch !== CHW'(last_ch) || o_data_sop !== 1'b0)
          $display("FAIL out_hold: got d=%h ch=%0d sop=%b want d=%h ch=%0d sop=0",
                   ov_data, ov_data_ch, o_data_sop, last_data, last_ch);
        else n_pass++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_rst_n = 0; i_dst_ready = 1; iv_ch_en = '1;
    for (int k = 0; k < CH; k++) fifo_q[k].delete();
    step(2);
    i_rst_n = 1;
    slog.delete(); outlog.delete();
  endtask

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) fifo_q[ch].push_back(DW'($urandom));
  endtask

  task automatic wait_strobes(input int n, input string nm);
    int t = 0;
    while (slog.size() < n && t < 200) begin step(1); t++; end
    n_chk++;
    if (slog.size() < n) $display("FAIL %s_timeout: got %0d strobes want %0d", nm, slog.size(), n);
    else n_pass++;
  endtask

  task automatic drain(input string nm);
    int t = 0, tot;
    do begin
      step(1); t++;
      tot = 0;
      for (int k = 0; k < CH; k++) tot += fifo_q[k].size();
    end while ((tot != 0 || expq.size() != 0) && t < 2000);
    step(3);
    n_chk++;
    if (tot != 0 || expq.size() != 0) $display("FAIL %s_drain: got %0d words left want 0", nm, tot + expq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    step(3);
    n_chk++;
    if ({ov_fifo_rd, o_data_wr, o_data_sop, ov_data, ov_data_ch} !== '0)
      $display("FAIL reset_outs: got rd=%b wr=%b sop=%b d=%h ch=%0d want all 0",
               ov_fifo_rd, o_data_wr, o_data_sop, ov_data, ov_data_ch);
    else n_pass++;
    i_rst_n = 1;
    step(4);
    n_chk++;
    if (ov_fifo_rd !== '0 || o_data_wr !== 1'b0) $display("FAIL idle_no_elig: got rd=%b wr=%b want 0", ov_fifo_rd, o_data_wr);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    fifo_q[2].push_back(8'hA1); fifo_q[2].push_back(8'hB2); fifo_q[2].push_back(8'hC3);
    step(12);
    n_chk++;
    if (slog.size() != 3 || outlog.size() != 3) $display("FAIL basic_count: got %0d strobes %0d words want 3 3", slog.size(), outlog.size());
    else begin
      n_pass++;
      n_chk++;
      if (slog[0].ch != 2 || slog[1].ch != 2 || slog[2].ch != 2 ||
          slog[1].cyc != slog[0].cyc + 1 || slog[2].cyc != slog[0].cyc + 2)
        $display("FAIL basic_strobes: got ch %0d,%0d,%0d want 2,2,2 consecutive", slog[0].ch, slog[1].ch, slog[2].ch);
      else n_pass++;
      n_chk++;
      if (outlog[0].cyc != slog[0].cyc + 2 || outlog[0].data !== 8'hA1 || outlog[1].data !== 8'hB2 ||
          outlog[2].data !== 8'hC3 || !outlog[0].sop || outlog[1].sop || outlog[2].sop)
        $display("FAIL basic_words: got %h %h %h lat %0d want a1 b2 c3 lat 2",
                 outlog[0].data, outlog[1].data, outlog[2].data, outlog[0].cyc - slog[0].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int rem[CH], ech[$], egap[$], n, plen = 0, bad = 0;
    do_reset();
    for (int c = 0; c < CH; c++) begin rem[c] = 40; push(c, 40); end
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0)
      for (int c = 0; c < CH; c++) begin
        n = (rem[c] < BURST) ? rem[c] : BURST;
        for (int j = 0; j < n; j++) begin
          ech.push_back(c);
          egap.push_back(j > 0 ? 1 : (ech.size() == 1 ? 0 : (plen == BURST ? 2 : 3)));
        end
        if (n > 0) plen = n;
        rem[c] -= n;
      end
    drain("rr");
    n_chk++;
    if (slog.size() != ech.size()) $display("FAIL rr_count: got %0d strobes want %0d", slog.size(), ech.size());
    else n_pass++;
    for (int i = 0; i < slog.size() && i < ech.size() && bad == 0; i++) begin
      n_chk++;
      if (slog[i].ch != ech[i] || (i > 0 && slog[i].cyc - slog[i-1].cyc != egap[i])) begin
        $display("FAIL rr_seq: strobe %0d got ch %0d gap %0d want ch %0d gap %0d", i, slog[i].ch,
                 i > 0 ? slog[i].cyc - slog[i-1].cyc : 0, ech[i], egap[i]);
        bad = 1;
      end else n_pass++;
    end
  endtask

  task automatic test_ready_drop();
    int s0, o0;
    do_reset();
    push(0, 20);
    wait_strobes(5, "drop");
    i_dst_ready = 0;
    s0 = slog.size(); o0 = outlog.size();
    step(5);
    n_chk++;
    if (slog.size() != s0) $display("FAIL drop_no_strobe: got %0d strobes want %0d", slog.size(), s0);
    else n_pass++;
    n_chk++;
    if (outlog.size() - o0 > 2) $display("FAIL drop_inflight: got %0d words want <=2", outlog.size() - o0);
    else n_pass++;
    i_dst_ready = 1;
    drain("drop");
    n_chk++;
    if (slog.size() <= s0 || slog[s0].ch != 0 || slog[s0].cyc - slog[s0-1].cyc != 6)
      $display("FAIL drop_resume: got %0d strobes want resume on ch 0 after 5-cycle hold", slog.size());
    else n_pass++;
    n_chk++;
    if (outlog.size() != 20) $display("FAIL drop_conserve: got %0d words want 20", outlog.size());
    else n_pass++;
  endtask

  task automatic test_ch_en();
    int n1 = 0;
    do_reset();
    iv_ch_en = 4'b1101;
    push(0, 5); push(1, 5); push(2, 5);
    step(60);
    foreach (slog[i]) if (slog[i].ch == 1) n1++;
    n_chk++;
    if (n1 != 0 || slog.size() != 10 || fifo_q[1].size() != 5)
      $display("FAIL en_block: got ch1 strobes %0d total %0d want 0 10", n1, slog.size());
    else n_pass++;
    do_reset();
    push(0, 10);
    wait_strobes(3, "en");
    iv_ch_en[0] = 1'b0;
    step(4);
    n_chk++;
    if (slog.size() != 3 || outlog.size() != 3)
      $display("FAIL en_stop: got %0d strobes %0d words want 3 3", slog.size(), outlog.size());
    else n_pass++;
    iv_ch_en = '1;
    drain("en");
    n_chk++;
    if (outlog.size() != 10) $display("FAIL en_conserve: got %0d words want 10", outlog.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    push(1, 10);
    wait_strobes(3, "rstmid");
    push(0, 5); push(2, 5);
    i_rst_n = 0;
    step(1);
    n_chk++;
    if ({ov_fifo_rd, o_data_wr, o_data_sop, ov_data, ov_data_ch} !== '0)
      $display("FAIL rstmid_outs: got rd=%b wr=%b sop=%b d=%h ch=%0d want all 0",
               ov_fifo_rd, o_data_wr, o_data_sop, ov_data, ov_data_ch);
    else n_pass++;
    i_rst_n = 1;
    s0 = slog.size();
    wait_strobes(s0 + 1, "rstmid_after");
    n_chk++;
    if (slog.size() <= s0 || slog[s0].ch != 0) $display("FAIL rstmid_first: got ch %0d want 0", slog.size() > s0 ? slog[s0].ch : -1);
    else n_pass++;
    drain("rstmid");
  endtask

  task automatic test_empty_mid();
    do_reset();
    push(0, 3); push(2, 4);
    drain("empty");
    n_chk++;
    if (slog.size() != 7 || slog[2].ch != 0 || slog[3].ch != 2 || slog[6].ch != 2 || slog[3].cyc - slog[2].cyc != 3)
      $display("FAIL empty_switch: got %0d strobes want 0x3 then 2x4 with gap 3", slog.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int pushed = 0, c;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, CH - 1);
        push(c, 1); pushed++;
      end
      i_dst_ready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) iv_ch_en = CH'($urandom);
      step(1);
    end
    iv_ch_en = '1; i_dst_ready = 1;
    drain("rand");
    n_chk++;
    if (outlog.size() != pushed) $display("FAIL rand_conserve: got %0d words want %0d", outlog.size(), pushed);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_ready_drop();
    test_ch_en();
    test_reset_mid();
    test_empty_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rdm_rr.md
RDM_RR -- requirements
Module: rdm_rr

Interface
REQ-001 Parameter DW, default 8, data width in bits per channel.
REQ-002 Parameter CH, default 4, number of FIFO channels (2..16).
REQ-003 Parameter BURST, default 16, maximum words read per grant (1..256).
REQ-004 Derived CHW = max(1, clog2(CH)) and CW = clog2(BURST+1), fixed internally, not overridable.
REQ-005 i_clk  input  1  sole clock; all logic on the rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous and active-low.
REQ-007 iv_fifo_empty  input  CH  per-channel FIFO empty flag, bit k = channel k.
REQ-008 iv_fifo_data  input  CH*DW  per-channel FIFO read data, channel k at bits [k*DW +: DW].
REQ-009 iv_ch_en  input  CH  per-channel service enable.
REQ-010 i_dst_ready  input  1  destination can accept data.
REQ-011 ov_fifo_rd  output  CH  per-channel FIFO read strobe, at most one bit high per cycle.
REQ-012 ov_data  output  DW  output data word.
REQ-013 o_data_wr  output  1  ov_data valid, one word per high cycle.
REQ-014 ov_data_ch  output  CHW  source channel of ov_data.
REQ-015 o_data_sop  output  1  first word of a grant, qualified by o_data_wr.

Function
REQ-016 The FIFO SHALL present read data in the cycle after the read strobe, with no further latency.
REQ-017 The FSM SHALL have states IDLE and READ; all other encodings SHALL return to IDLE on the next edge.
REQ-018 Channel k SHALL be eligible when iv_fifo_empty[k]=0 and iv_ch_en[k]=1.
REQ-019 In IDLE with at least one eligible channel, the block SHALL grant the first eligible channel after the last-granted one, in ascending index order with wrap from CH-1 to 0, clear the burst counter, and enter READ.
REQ-020 In IDLE with no eligible channel, the block SHALL remain in IDLE with ov_fifo_rd all zero.
REQ-021 ov_fifo_rd[g] SHALL be combinational: high only when state=READ, g is the granted channel, channel g is eligible, i_dst_ready=1, and the burst count is below BURST.
REQ-022 Each read strobe SHALL increment the CW-bit burst counter by 1; the counter SHALL NOT wrap.
REQ-023 READ SHALL return to IDLE on the edge where the strobe raises the count to BURST, or in any cycle where the granted channel is not eligible.
REQ-024 In READ with i_dst_ready=0 and the channel still eligible, the block SHALL hold the grant and issue no strobe.
REQ-025 The block SHALL capture the FIFO word one cycle after the strobe, then drive ov_data, ov_data_ch and o_data_wr=1 in the following cycle (strobe-to-o_data_wr latency 2 cycles).
REQ-026 o_data_sop SHALL be 1 only on the word produced by the first strobe of a grant.
REQ-027 The destination SHALL accept up to 2 words after it deasserts i_dst_ready; the block SHALL drop no in-flight word.
REQ-028 ov_data and ov_data_ch SHALL hold their last value while o_data_wr=0.
REQ-029 Clearing iv_ch_en for the granted channel mid-burst SHALL stop strobes in that same cycle; words already strobed SHALL still be output.
REQ-030 IDLE-to-READ SHALL take one cycle, so back-to-back grants have a one-cycle strobe gap.

Reset
REQ-031 While i_rst_n=0 at a clock edge, the block SHALL set the state to IDLE, the burst counter to 0, o_data_wr, o_data_sop and the capture pipeline valid bits to 0, ov_data to 0, and ov_data_ch to 0.
REQ-032 Reset SHALL set the last-granted pointer to CH-1, so channel 0 has first priority.
REQ-033 ov_fifo_rd SHALL be all zero during reset, and in-flight words SHALL be discarded with no o_data_wr after reset.

Verification
REQ-034 Reset, then channel 2 holds 3 words (A,B,C), others empty, ready=1 -> rd[2] strobed 3 consecutive cycles; o_data_wr high 3 cycles starting 2 cycles after the first strobe; data A,B,C; ch=2; sop only on A.
REQ-035 All 4 channels hold 40 words each, BURST=16 -> grant order 0,1,2,3,0,...; each grant is 16 strobes, then a 1-cycle gap.
REQ-036 ready dropped for 5 cycles mid-burst -> no strobes during the drop, at most 2 further o_data_wr, the burst resumes on the same channel, and total words are conserved.
REQ-037 iv_ch_en[1]=0 while channel 1 is non-empty -> channel 1 is never strobed; clearing en mid-burst stops strobes in the same cycle.
REQ-038 Reset asserted mid-burst -> the next cycle has all outputs zero and no trailing o_data_wr; after release, channel 0 is served first.
REQ-039 Channel empties mid-burst with others non-empty -> return to IDLE, then grant the next eligible channel; no strobe occurs while empty=1.
